// File: rtl/mux_2a1_cond.sv
// ----------------------------------------------------------------------------
// mux_2a1_cond
//   2:1 lane multiplexer. It merges two WIDTH-bit lanes, each running at word
//   rate f, into one WIDTH-bit stream at 2f. Each pair is emitted in the order
//   lane 0 word, then lane 1 word. The block runs on the single clock clk2f.
//   It generates the f-rate phase internally and exports it so the upstream
//   logic can align to it.
//
// Ports
//   clk2f         in   1      only clock of the block
//   reset         in   1      synchronous reset, active-high
//   data_in_0_c   in   WIDTH  lane 0 word
//   valid_in_0_c  in   1      lane 0 word valid
//   data_in_1_c   in   WIDTH  lane 1 word
//   valid_in_1_c  in   1      lane 1 word valid
//   data_out_c    out  WIDTH  merged stream word (IDLE_VAL in invalid slots)
//   valid_out_c   out  1      merged stream word valid
//   lane_id_c     out  1      source lane of the current data_out_c
//   phase_c       out  1      f-rate phase; upstream updates lanes while it is 1
// ----------------------------------------------------------------------------
module mux_2a1_cond #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] IDLE_VAL = 8'h00
) (
    input  logic             clk2f,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in_0_c,
    input  logic             valid_in_0_c,
    input  logic [WIDTH-1:0] data_in_1_c,
    input  logic             valid_in_1_c,
    output logic [WIDTH-1:0] data_out_c,
    output logic             valid_out_c,
    output logic             lane_id_c,
    output logic             phase_c
);

    // Slot encoding of the internal phase register.
    localparam logic [0:0] PH_SAMPLE = 1'b0;  // both lanes captured, lane 0 emitted
    localparam logic [0:0] PH_SECOND = 1'b1;  // held lane 1 word emitted

    logic [0:0]       ph_q,        ph_d;
    logic [WIDTH-1:0] hold_data_q, hold_data_d;
    logic             hold_vld_q,  hold_vld_d;
    logic [WIDTH-1:0] data_q,      data_d;
    logic             valid_q,     valid_d;
    logic             lane_q,      lane_d;

    // Next-state selection for the two output slots of each pair.
    always_comb begin
        ph_d        = ~ph_q;
        hold_data_d = hold_data_q;
        hold_vld_d  = hold_vld_q;
        data_d      = data_q;
        valid_d     = valid_q;
        lane_d      = lane_q;
        case (ph_q)
            PH_SAMPLE: begin
                // Lane 1 is captured together with lane 0. A change on lane 1
                // during the second slot therefore cannot corrupt this pair.
                valid_d     = valid_in_0_c;
                lane_d      = 1'b0;
                hold_data_d = data_in_1_c;
                hold_vld_d  = valid_in_1_c;
                if (valid_in_0_c) begin
                    data_d = data_in_0_c;
                end else begin
                    data_d = IDLE_VAL;
                end
            end
            PH_SECOND: begin
                // Lane inputs are deliberately ignored in this slot.
                valid_d = hold_vld_q;
                lane_d  = 1'b1;
                if (hold_vld_q) begin
                    data_d = hold_data_q;
                end else begin
                    data_d = IDLE_VAL;
                end
            end
            default: begin
                ph_d    = PH_SAMPLE;
                data_d  = IDLE_VAL;
                valid_d = 1'b0;
                lane_d  = 1'b0;
            end
        endcase
    end

    // State registers. A reset edge clears everything and drops any pending
    // lane 1 word, so the next pair is sampled on the first edge after release.
    always_ff @(posedge clk2f) begin
        if (reset) begin
            ph_q        <= PH_SAMPLE;
            hold_data_q <= {WIDTH{1'b0}};
            hold_vld_q  <= 1'b0;
            data_q      <= {WIDTH{1'b0}};
            valid_q     <= 1'b0;
            lane_q      <= 1'b0;
        end else begin
            ph_q        <= ph_d;
            hold_data_q <= hold_data_d;
            hold_vld_q  <= hold_vld_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            lane_q      <= lane_d;
        end
    end

    assign data_out_c  = data_q;
    assign valid_out_c = valid_q;
    assign lane_id_c   = lane_q;
    assign phase_c     = ph_q[0];

endmodule
